// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard-tracking pipeline registers.
// Entries carry PC, instruction, destination register and remaining latency.
package hazard_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int unsigned TNEW_W   = 2;
    localparam int unsigned A3_W     = 5;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic [A3_W-1:0]   a3;
        logic [TNEW_W-1:0] t_new;
    } stage_t;

    // Reset value and stall filler are the same entry; a real `sll $0,$0,0` looks identical.
    localparam stage_t BUBBLE = '{pc: RESET_PC, instr: '0, a3: '0, t_new: '0};

    function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    function automatic stage_t make_entry(input logic [31:0]       pc,
                                          input logic [31:0]       instr,
                                          input logic [A3_W-1:0]   a3,
                                          input logic [TNEW_W-1:0] t_new);
        stage_t e;
        e.pc    = pc;
        e.instr = instr;
        e.a3    = a3;
        // No destination means nothing to wait for.
        e.t_new = (a3 == '0) ? '0 : t_new;
        return e;
    endfunction

endpackage

// File: rtl/hazard_pipe_track_stage_reg.sv
// One pipeline register of hazard bookkeeping with hold, bubble-insert and
// saturating T_new decrement controls; reset is synchronous and active-low.
module stage_reg
    import hazard_pkg::*;
#(
    parameter stage_t ResetVal = BUBBLE
) (
    input  logic   clk_i,
    input  logic   reset_ni,
    input  logic   en_i,
    input  logic   bubble_i,
    input  logic   dec_i,
    input  stage_t d_i,
    output stage_t q_o
);

    stage_t q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (bubble_i) begin
            q_d = BUBBLE;
        end else if (en_i) begin
            q_d = d_i;
            if (dec_i) begin
                q_d.t_new = tnew_dec(d_i.t_new);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            q_q <= ResetVal;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/hazard_pipe_track.sv
// F/D -> D/E -> E/M -> M/W register chain for hazard bookkeeping, stalled by `stop`.
// Optional stall/retire counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_pipe_track
    import hazard_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stop,
    input  logic [31:0]       F_pc,
    input  logic [31:0]       F_instr,
    input  logic [A3_W-1:0]   D_A3,
    input  logic [TNEW_W-1:0] D_T_new,
    output logic [31:0]       D_pc,
    output logic [31:0]       D_instr,
    output logic [31:0]       E_pc,
    output logic [31:0]       E_instr,
    output logic [A3_W-1:0]   E_A3,
    output logic [TNEW_W-1:0] E_T_new,
    output logic [31:0]       M_pc,
    output logic [31:0]       M_instr,
    output logic [A3_W-1:0]   M_A3,
    output logic [TNEW_W-1:0] M_T_new,
    output logic [31:0]       W_pc,
    output logic [31:0]       W_instr,
    output logic [A3_W-1:0]   W_A3,
    output logic [TNEW_W-1:0] W_T_new
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       retire_cnt
`endif
);

    stage_t fd_d, fd_q;
    stage_t de_d, de_q;
    stage_t em_q, mw_q;

    assign fd_d = make_entry(F_pc, F_instr, '0, '0);
    assign de_d = make_entry(fd_q.pc, fd_q.instr, D_A3, D_T_new);

    stage_reg #(
        .ResetVal (BUBBLE)
    ) u_fd (
        .clk_i    (clk),
        .reset_ni (reset),
        .en_i     (~stop),
        .bubble_i (1'b0),
        .dec_i    (1'b0),
        .d_i      (fd_d),
        .q_o      (fd_q)
    );

    stage_reg #(
        .ResetVal (BUBBLE)
    ) u_de (
        .clk_i    (clk),
        .reset_ni (reset),
        .en_i     (1'b1),
        .bubble_i (stop),
        .dec_i    (1'b0),
        .d_i      (de_d),
        .q_o      (de_q)
    );

    // E, M and W never freeze; stalls only affect F/D and D/E.
    stage_reg #(
        .ResetVal (BUBBLE)
    ) u_em (
        .clk_i    (clk),
        .reset_ni (reset),
        .en_i     (1'b1),
        .bubble_i (1'b0),
        .dec_i    (1'b1),
        .d_i      (de_q),
        .q_o      (em_q)
    );

    stage_reg #(
        .ResetVal (BUBBLE)
    ) u_mw (
        .clk_i    (clk),
        .reset_ni (reset),
        .en_i     (1'b1),
        .bubble_i (1'b0),
        .dec_i    (1'b1),
        .d_i      (em_q),
        .q_o      (mw_q)
    );

    // F/D carries no hazard fields; they stay at zero.
    logic unused_fd;
    assign unused_fd = ^{fd_q.a3, fd_q.t_new};

    assign D_pc    = fd_q.pc;
    assign D_instr = fd_q.instr;

    assign E_pc    = de_q.pc;
    assign E_instr = de_q.instr;
    assign E_A3    = de_q.a3;
    assign E_T_new = de_q.t_new;

    assign M_pc    = em_q.pc;
    assign M_instr = em_q.instr;
    assign M_A3    = em_q.a3;
    assign M_T_new = em_q.t_new;

    assign W_pc    = mw_q.pc;
    assign W_instr = mw_q.instr;
    assign W_A3    = mw_q.a3;
    assign W_T_new = mw_q.t_new;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_d, stall_cnt_q;
    logic [31:0] retire_cnt_d, retire_cnt_q;

    // Retirement is counted as the entry moves from M into W.
    always_comb begin
        stall_cnt_d  = stall_cnt_q + {31'b0, stop};
        retire_cnt_d = retire_cnt_q + {31'b0, (em_q.instr != '0)};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign retire_cnt = retire_cnt_q;
`else
    // Counters are compiled out; the pipeline itself is unchanged.
`endif

endmodule

// File: tb/tb_hazard_pipe_track.sv
// Self-checking bench for hazard_pipe_track: directed scenarios plus a randomized
// run compared against a latency/history model of the pipeline.
module tb_hazard_pipe_track;

    localparam logic [31:0] RPC = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  a3;
        logic [1:0]  tnew;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset, stop;
    logic [31:0] F_pc, F_instr;
    logic [4:0]  D_A3;
    logic [1:0]  D_T_new;
    logic [31:0] D_pc, D_instr, E_pc, E_instr, M_pc, M_instr, W_pc, W_instr;
    logic [4:0]  E_A3, M_A3, W_A3;
    logic [1:0]  E_T_new, M_T_new, W_T_new;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, retire_cnt;
`endif

    always #5 clk = ~clk;

    hazard_pipe_track dut (
        .clk        (clk),
        .reset      (reset),
        .stop       (stop),
        .F_pc       (F_pc),
        .F_instr    (F_instr),
        .D_A3       (D_A3),
        .D_T_new    (D_T_new),
        .D_pc       (D_pc),
        .D_instr    (D_instr),
        .E_pc       (E_pc),
        .E_instr    (E_instr),
        .E_A3       (E_A3),
        .E_T_new    (E_T_new),
        .M_pc       (M_pc),
        .M_instr    (M_instr),
        .M_A3       (M_A3),
        .M_T_new    (M_T_new),
        .W_pc       (W_pc),
        .W_instr    (W_instr),
        .W_A3       (W_A3),
        .W_T_new    (W_T_new)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .retire_cnt (retire_cnt)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: D contents, plus the last three entries that entered E (index 0 newest).
    logic [31:0] m_dpc, m_dinstr;
    ent_t        hist[3];
    logic [31:0] m_stalls, m_retires;

    function automatic ent_t bubble_e();
        ent_t b;
        b.pc = RPC; b.instr = '0; b.a3 = '0; b.tnew = '0;
        return b;
    endfunction

    // An entry k stages past E has waited k cycles; latency can't go below zero.
    function automatic ent_t aged(input ent_t e, input int k);
        ent_t r;
        r = e;
        r.tnew = (int'(e.tnew) > k) ? 2'(int'(e.tnew) - k) : 2'd0;
        return r;
    endfunction

    task automatic step(input logic rst, input logic stp, input logic [31:0] fpc,
                        input logic [31:0] finstr, input logic [4:0] a3,
                        input logic [1:0] tn);
        ent_t ne;
        reset = rst; stop = stp; F_pc = fpc; F_instr = finstr; D_A3 = a3; D_T_new = tn;
        @(posedge clk);
        if (!rst) begin
            m_dpc = RPC; m_dinstr = '0;
            for (int i = 0; i < 3; i++) hist[i] = bubble_e();
            m_stalls = '0; m_retires = '0;
        end else begin
            if (stp) ne = bubble_e();
            else begin
                ne.pc = m_dpc; ne.instr = m_dinstr; ne.a3 = a3;
                ne.tnew = (a3 == 5'd0) ? 2'd0 : tn;
            end
            if (hist[1].instr != 32'd0) m_retires = m_retires + 1;
            if (stp) m_stalls = m_stalls + 1;
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = ne;
            if (!stp) begin m_dpc = fpc; m_dinstr = finstr; end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [275:0] exp_all;
        step(1'b0, 1'b0, $urandom, $urandom, 5'd7, 2'd2);
        step(1'b0, $urandom_range(0, 1) == 1, $urandom, $urandom, 5'd3, 2'd1);
        exp_all = {RPC, 32'd0, RPC, 32'd0, 5'd0, 2'd0, RPC, 32'd0, 5'd0, 2'd0,
                   RPC, 32'd0, 5'd0, 2'd0};
        n_total++;
        if ({D_pc, D_instr, E_pc, E_instr, E_A3, E_T_new, M_pc, M_instr, M_A3, M_T_new,
             W_pc, W_instr, W_A3, W_T_new} !== exp_all)
            $display("FAIL reset_state: got D=%h/%h E=%h/%h/%0d/%0d M=%h/%h W=%h/%h",
                     D_pc, D_instr, E_pc, E_instr, E_A3, E_T_new, M_pc, M_instr, W_pc, W_instr);
        else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
        n_total++;
        if ({stall_cnt, retire_cnt} !== 64'd0)
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, retire_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_straight_flow();
        step(1'b1, 1'b0, 32'h0000_3000, 32'h2008_0001, 5'd8, 2'd2);
        n_total++;
        if ({D_pc, D_instr} !== {32'h0000_3000, 32'h2008_0001})
            $display("FAIL flow_D: got %h/%h want 00003000/20080001", D_pc, D_instr);
        else n_pass++;
        step(1'b1, 1'b0, 32'h0000_3004, 32'h2009_0002, 5'd8, 2'd2);
        n_total++;
        if ({E_pc, E_instr, E_A3, E_T_new} !== {32'h0000_3000, 32'h2008_0001, 5'd8, 2'd2})
            $display("FAIL flow_E: got %h/%h/%0d/%0d want 00003000/20080001/8/2",
                     E_pc, E_instr, E_A3, E_T_new);
        else n_pass++;
        step(1'b1, 1'b0, 32'h0000_3008, 32'h200a_0003, 5'd8, 2'd2);
        n_total++;
        if ({M_pc, M_A3, M_T_new} !== {32'h0000_3000, 5'd8, 2'd1})
            $display("FAIL flow_M: got %h/%0d/%0d want 00003000/8/1", M_pc, M_A3, M_T_new);
        else n_pass++;
        step(1'b1, 1'b0, 32'h0000_300c, 32'h200b_0004, 5'd8, 2'd2);
        n_total++;
        if ({W_pc, W_instr, W_A3, W_T_new} !== {32'h0000_3000, 32'h2008_0001, 5'd8, 2'd0})
            $display("FAIL flow_W: got %h/%h/%0d/%0d want 00003000/20080001/8/0",
                     W_pc, W_instr, W_A3, W_T_new);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] s0;
        step(1'b1, 1'b0, 32'h0000_3010, 32'h8c01_0010, 5'd4, 2'd1);
        s0 = m_stalls;
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 32'h0000_3014, 32'h8c02_0014, 5'd4, 2'd1);
            n_total++;
            if ({D_pc, D_instr} !== {32'h0000_3010, 32'h8c01_0010})
                $display("FAIL stall_hold_D%0d: got %h/%h want 00003010/8c010010",
                         k, D_pc, D_instr);
            else n_pass++;
            n_total++;
            if ({E_pc, E_instr, E_A3, E_T_new} !== {RPC, 32'd0, 5'd0, 2'd0})
                $display("FAIL stall_bubble_E%0d: got %h/%h/%0d/%0d want 00003000/0/0/0",
                         k, E_pc, E_instr, E_A3, E_T_new);
            else n_pass++;
        end
        step(1'b1, 1'b0, 32'h0000_3014, 32'h8c02_0014, 5'd4, 2'd1);
        n_total++;
        if ({E_pc, E_instr, E_A3, E_T_new} !== {32'h0000_3010, 32'h8c01_0010, 5'd4, 2'd1})
            $display("FAIL stall_release_E: got %h/%h/%0d/%0d want 00003010/8c010010/4/1",
                     E_pc, E_instr, E_A3, E_T_new);
        else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
        n_total++;
        if (stall_cnt !== s0 + 32'd2)
            $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, s0 + 32'd2);
        else n_pass++;
`endif
    endtask

    task automatic test_no_write();
        step(1'b1, 1'b0, 32'h0000_3020, 32'h1000_0003, 5'd0, 2'd2);
        n_total++;
        if (E_T_new !== 2'd0) $display("FAIL no_write_tnew: got %0d want 0", E_T_new);
        else n_pass++;
    endtask

    task automatic test_saturation();
        step(1'b1, 1'b0, 32'h0000_3024, 32'h0000_0000, 5'd5, 2'd0);
        n_total++;
        if ({E_A3, E_T_new} !== {5'd5, 2'd0})
            $display("FAIL sat_E: got %0d/%0d want 5/0", E_A3, E_T_new);
        else n_pass++;
        step(1'b1, 1'b0, 32'h0000_3028, 32'h0000_0000, 5'd9, 2'd2);
        n_total++;
        if ({M_A3, M_T_new} !== {5'd5, 2'd0})
            $display("FAIL sat_M: got %0d/%0d want 5/0", M_A3, M_T_new);
        else n_pass++;
        step(1'b1, 1'b0, 32'h0000_302c, 32'h0000_0000, 5'd9, 2'd2);
        n_total++;
        if ({W_A3, W_T_new} !== {5'd5, 2'd0})
            $display("FAIL sat_W: got %0d/%0d want 5/0", W_A3, W_T_new);
        else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        step(1'b1, 1'b1, 32'h0000_3030, 32'h2222_2222, 5'd6, 2'd2);
        step(1'b0, 1'b1, 32'h0000_3034, 32'h3333_3333, 5'd6, 2'd2);
        n_total++;
        if ({D_pc, D_instr, E_pc, E_instr, E_A3, E_T_new, M_pc, M_instr, W_pc, W_instr}
            !== {RPC, 32'd0, RPC, 32'd0, 5'd0, 2'd0, RPC, 32'd0, RPC, 32'd0})
            $display("FAIL reset_mid_stall: got D=%h/%h E=%h/%h M=%h/%h W=%h/%h",
                     D_pc, D_instr, E_pc, E_instr, M_pc, M_instr, W_pc, W_instr);
        else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
        n_total++;
        if (stall_cnt !== 32'd0)
            $display("FAIL reset_mid_stall_cnt: got %0d want 0", stall_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_random();
        ent_t exp_e;
        for (int c = 0; c < 300; c++) begin
            step($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0, $urandom,
                 ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom,
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 2'($urandom_range(0, 2)));
            n_total++;
            if ({D_pc, D_instr} !== {m_dpc, m_dinstr})
                $display("FAIL rand_D c%0d: got %h/%h want %h/%h",
                         c, D_pc, D_instr, m_dpc, m_dinstr);
            else n_pass++;
            exp_e = hist[0];
            n_total++;
            if ({E_pc, E_instr, E_A3, E_T_new} !== exp_e)
                $display("FAIL rand_E c%0d: got %h want %h",
                         c, {E_pc, E_instr, E_A3, E_T_new}, exp_e);
            else n_pass++;
            exp_e = aged(hist[1], 1);
            n_total++;
            if ({M_pc, M_instr, M_A3, M_T_new} !== exp_e)
                $display("FAIL rand_M c%0d: got %h want %h",
                         c, {M_pc, M_instr, M_A3, M_T_new}, exp_e);
            else n_pass++;
            exp_e = aged(hist[2], 2);
            n_total++;
            if ({W_pc, W_instr, W_A3, W_T_new} !== exp_e)
                $display("FAIL rand_W c%0d: got %h want %h",
                         c, {W_pc, W_instr, W_A3, W_T_new}, exp_e);
            else n_pass++;
`ifdef HAZARD_PERF_CNT_EN
            n_total++;
            if ({stall_cnt, retire_cnt} !== {m_stalls, m_retires})
                $display("FAIL rand_cnt c%0d: got %0d/%0d want %0d/%0d",
                         c, stall_cnt, retire_cnt, m_stalls, m_retires);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        reset = 1'b0; stop = 1'b0; F_pc = '0; F_instr = '0; D_A3 = '0; D_T_new = '0;
        m_dpc = RPC; m_dinstr = '0; m_stalls = '0; m_retires = '0;
        for (int i = 0; i < 3; i++) hist[i] = bubble_e();
        test_reset();
        test_straight_flow();
        test_stall();
        test_no_write();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
